mdu_seq: RTL and testbench
==========================

# mdu_seq

Iterative 32-bit multiply/divide sequencer for the CPU's HI/LO unit. It time-shares one WIDTH+1-bit carry-lookahead add/subtract datapath, built from 16-bit lookahead slices, across radix-2 shift-add multiply and restoring divide iterations. It sits beside the EX stage: EX issues MULT/MULTU/DIV/DIVU, stalls on BUSY and captures HI/LO on DONE.

## Interface
- WIDTH, 32: operand width; must be a multiple of 16; iteration count = WIDTH.
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- START  in  1  request; accepted only in IDLE or DONE state.
- OP  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with START.
- SRC_A  in  WIDTH  multiplicand or dividend; sampled with START.
- SRC_B  in  WIDTH  multiplier or divisor; sampled with START.
- CANCEL  in  1  pipeline flush; aborts any operation.
- BUSY  out  1  high in PREP, ITER and FIX.
- DONE  out  1  one-cycle completion pulse.
- DIV_ZERO  out  1  valid with DONE; divisor was zero.
- HI  out  WIDTH  product high half or remainder.
- LO  out  WIDTH  product low half or quotient.

## Operation
- States: IDLE, PREP, ITER, FIX, DONE. Reset: IDLE, with BUSY=DONE=DIV_ZERO=0 and HI=LO=0.
- IDLE/DONE with START=1 and CANCEL=0: latch OP and operands, then go to PREP. Otherwise IDLE stays IDLE and DONE goes to IDLE.
- PREP: for signed ops, take magnitudes using the shared datapath. Record result sign: product and quotient sign = a^b; remainder sign = sign of a. Clear iteration counter.
- PREP exit, divide with SRC_B=0: go to DONE with DIV_ZERO=1, HI=SRC_A (raw), LO=all ones.
- PREP exit, otherwise: go to ITER.
- ITER, multiply: if the multiplier LSB is set, add the multiplicand into the upper accumulator (WIDTH+1-bit sum). Shift {carry, acc, multiplier} right by 1.
- ITER, divide: shift {rem, quo} left by 1, then compute rem − divisor. If there is no borrow, keep the difference and set the quotient LSB to 1; otherwise restore.
- Exactly one add/sub per cycle. Counter runs 0..WIDTH−1; at WIDTH−1 go to FIX.
- FIX: negate the 2·WIDTH product (two passes not permitted; use the datapath plus an incrementing carry chain) or the quotient/remainder as their signs require. Then go to DONE.
- DONE: HI/LO registers load on entry and hold until the next completion. DONE=1 for exactly one cycle.
- Signed DIV of 0x80000000 by 0xFFFFFFFF yields LO=0x80000000, HI=0 (natural wrap). No overflow flag.
- CANCEL=1 in any state: go to IDLE next cycle. No DONE; HI/LO unchanged. CANCEL wins over a simultaneous START.
- START while BUSY: ignored, with no effect on operands.

## Timing
- START accepted at cycle 0. PREP is cycle 1, ITER is cycles 2..WIDTH+1, FIX is cycle WIDTH+2, DONE is cycle WIDTH+3 (35 for WIDTH=32).
- BUSY rises at cycle 1 and falls at cycle WIDTH+3.
- Divide-by-zero: DONE at cycle 2.
- Back-to-back: START in the DONE cycle is accepted, so PREP follows immediately.
- HI/LO/DIV_ZERO are registered and change only on entry to DONE.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous).

## Configuration
- MDU_MUL_ZERO_SKIP_EN defined: for a multiply where either operand magnitude is zero, PREP goes directly to FIX, so DONE comes at cycle 3 with HI=LO=0.
- Undefined: every multiply takes the full WIDTH+3 cycles. Divide timing is identical in both builds.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> DONE at cycle 35, HI=0xFFFFFFFE, LO=0x00000001, BUSY high cycles 1–34.
- MULT −3 × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then DIV −7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 0 -> DONE at cycle 2, DIV_ZERO=1, HI=100, LO=0xFFFFFFFF. Next DIVU 100/7 -> DIV_ZERO=0, LO=14, HI=2.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. START held high through BUSY is ignored, and a new START in the DONE cycle begins the next op at cycle 36.
- MULTU 5×6 with CANCEL at cycle 10 -> IDLE at cycle 11, no DONE, HI/LO keep previous values. RST_N low at cycle 20 of a divide -> outputs zero asynchronously.
- MULT 0 × 12345: with MDU_MUL_ZERO_SKIP_EN, DONE at cycle 3; without it, DONE at cycle 35. HI=LO=0 in both builds.

Source files
------------

// File: rtl/mdu_seq_if.sv
// mdu_seq_if: request/result bundle between the EX stage and the mdu_seq multiply/divide sequencer
// Ports (signals):
//   start, op[1:0], src_a, src_b, cancel   EX -> sequencer (request, operands, pipeline flush)
//   busy, done, div_zero, hi, lo           sequencer -> EX (stall, completion pulse, results)
// Modports: master = EX side, slave = sequencer side.
interface mdu_seq_if #(parameter int WIDTH = 32);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             cancel;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   modport master (output start, op, src_a, src_b, cancel, input busy, done, div_zero, hi, lo);
   modport slave (input start, op, src_a, src_b, cancel, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: iterative multiply/divide sequencer (MULTU/MULT/DIVU/DIV) for the HI/LO unit.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   m      mdu_seq_if.slave: start/op/src_a/src_b/cancel in, busy/done/div_zero/hi/lo out
// One WIDTH+1-bit carry-lookahead adder (16-bit slices) is shared by PREP, ITER and FIX.
// Build option: MDU_MUL_ZERO_SKIP_EN lets a multiply with a zero operand go PREP -> FIX.
module mdu_seq #(
   parameter int WIDTH = 32
) (
   input logic      clk,
   input logic      rst_n,
   mdu_seq_if.slave m
);
   localparam int NS = WIDTH / 16;
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] acc_q, acc_d, wlo_q, wlo_d, mc_q, mc_d, hi_q, hi_d, lo_q, lo_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ps_q, ps_d, rs_q, rs_d, bneg_q, bneg_d, dz_q, dz_d;
   logic [WIDTH:0]   dp_x, dp_y, dp_s, r_sh, inc;
   logic             dp_ci, is_mul, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, hi_fix, lo_fix;

   // Carry-lookahead add: per-slice group generate/propagate, slice carries from the
   // group terms, then bit carries inside each slice; the extra top bit rides on the last carry.
   function automatic logic [WIDTH:0] cla_add(input logic [WIDTH:0] x, input logic [WIDTH:0] y, input logic ci);
      logic [WIDTH-1:0] g, p;
      logic [NS-1:0]    sg, sp;
      logic [NS:0]      sc;
      logic [WIDTH:0]   bc;
      g = x[WIDTH-1:0] & y[WIDTH-1:0];
      p = x[WIDTH-1:0] ^ y[WIDTH-1:0];
      sg = '0;
      sp = '1;
      for (int s = 0; s < NS; s++) begin
         for (int i = 0; i < 16; i++) begin
            sg[s] = g[16*s+i] | (p[16*s+i] & sg[s]);
            sp[s] = sp[s] & p[16*s+i];
         end
      end
      sc[0] = ci;
      for (int s = 0; s < NS; s++) sc[s+1] = sg[s] | (sp[s] & sc[s]);
      bc = '0;
      for (int s = 0; s < NS; s++) begin
         bc[16*s] = sc[s];
         for (int i = 0; i < 15; i++) bc[16*s+i+1] = g[16*s+i] | (p[16*s+i] & bc[16*s+i]);
      end
      bc[WIDTH] = sc[NS];
      return {x[WIDTH] ^ y[WIDTH] ^ bc[WIDTH], p ^ bc[WIDTH-1:0]};
   endfunction

   assign is_mul = !op_q[1];
   // During PREP the raw operands still sit in mc_q (a) and wlo_q (b).
   assign a_neg  = op_q[0] & mc_q[WIDTH-1];
   assign b_neg  = op_q[0] & wlo_q[WIDTH-1];
   assign a_mag  = a_neg ? dp_s[WIDTH-1:0] : mc_q;
   assign r_sh   = {acc_q, wlo_q[WIDTH-1]};
   // Low-half negation uses its own increment chain so FIX needs only one datapath pass.
   assign inc    = {1'b0, ~wlo_q} + {{WIDTH{1'b0}}, 1'b1};
   assign hi_fix = (is_mul ? ps_q : rs_q) ? dp_s[WIDTH-1:0] : acc_q;
   assign lo_fix = ps_q ? inc[WIDTH-1:0] : wlo_q;
   assign dp_s   = cla_add(dp_x, dp_y, dp_ci);

   // Datapath operand select. A negative signed divisor is kept raw and added
   // (rem + b == rem - |b|), so PREP only ever negates the dividend/multiplicand.
   always_comb begin
      dp_x  = '0;
      dp_y  = '0;
      dp_ci = 1'b0;
      if (state_q == PREP) begin
         dp_y  = ~{1'b0, mc_q};
         dp_ci = 1'b1;
      end else if (state_q == ITER && is_mul) begin
         dp_x = {1'b0, acc_q};
         dp_y = {1'b0, mc_q};
      end else if (state_q == ITER) begin
         dp_x  = r_sh;
         dp_y  = bneg_q ? {mc_q[WIDTH-1], mc_q} : ~{1'b0, mc_q};
         dp_ci = !bneg_q;
      end else if (state_q == FIX) begin
         dp_x  = {1'b0, ~acc_q};
         dp_ci = is_mul ? inc[WIDTH] : 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      acc_d   = acc_q;
      wlo_d   = wlo_q;
      mc_d    = mc_q;
      cnt_d   = cnt_q;
      ps_d    = ps_q;
      rs_d    = rs_q;
      bneg_d  = bneg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dz_d    = dz_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = m.start ? PREP : IDLE;
            if (m.start) begin
               op_d  = m.op;
               mc_d  = m.src_a;
               wlo_d = m.src_b;
            end
         end
         PREP: begin
            cnt_d  = '0;
            ps_d   = a_neg ^ b_neg;
            rs_d   = a_neg;
            bneg_d = b_neg;
            if (is_mul) begin
               // |a|*|b| = |a|*~b + |a| for negative b: seed the accumulator with |a|.
               mc_d    = a_mag;
               wlo_d   = b_neg ? ~wlo_q : wlo_q;
               acc_d   = b_neg ? a_mag : '0;
               state_d = ITER;
`ifdef MDU_MUL_ZERO_SKIP_EN
               if (mc_q == '0 || wlo_q == '0) begin
                  acc_d   = '0;
                  wlo_d   = '0;
                  state_d = FIX;
               end
`endif
            end else if (wlo_q == '0) begin
               hi_d    = mc_q;
               lo_d    = '1;
               dz_d    = 1'b1;
               state_d = DONE;
            end else begin
               mc_d    = wlo_q;
               wlo_d   = a_mag;
               acc_d   = '0;
               state_d = ITER;
            end
         end
         ITER: begin
            cnt_d   = cnt_q + CW'(1);
            state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : ITER;
            if (is_mul) begin
               {acc_d, wlo_d} = {wlo_q[0] ? dp_s : {1'b0, acc_q}, wlo_q[WIDTH-1:1]};
            end else begin
               // Top bit of the difference set means borrow: restore.
               acc_d = dp_s[WIDTH] ? r_sh[WIDTH-1:0] : dp_s[WIDTH-1:0];
               wlo_d = {wlo_q[WIDTH-2:0], !dp_s[WIDTH]};
            end
         end
         FIX: begin
            hi_d    = hi_fix;
            lo_d    = lo_fix;
            dz_d    = 1'b0;
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
      if (m.cancel) begin
         state_d = IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
         dz_d    = dz_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         acc_q   <= '0;
         wlo_q   <= '0;
         mc_q    <= '0;
         cnt_q   <= '0;
         ps_q    <= 1'b0;
         rs_q    <= 1'b0;
         bneg_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         wlo_q   <= wlo_d;
         mc_q    <= mc_d;
         cnt_q   <= cnt_d;
         ps_q    <= ps_d;
         rs_q    <= rs_d;
         bneg_q  <= bneg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dz_q    <= dz_d;
      end
   end

   assign m.busy     = state_q inside {PREP, ITER, FIX};
   assign m.done     = state_q == DONE;
   assign m.div_zero = dz_q;
   assign m.hi       = hi_q;
   assign m.lo       = lo_q;
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: self-checking bench for mdu_seq (vector table, corner sequences, random vs. arithmetic model)
module tb_mdu_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   lat, bb, cnt;
   logic [1:0]  rop;
   logic [31:0] ra, rb;
   logic [64:0] ex;

`ifdef MDU_MUL_ZERO_SKIP_EN
   localparam int ZL = 3;
`else
   localparam int ZL = 35;
`endif

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          lat;
   } vec_t;
   vec_t tv[8];

   mdu_seq_if #(.WIDTH(32)) bus ();
   mdu_seq #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .m(bus));

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Issue one op (inputs driven in cycle 0), return latency to DONE and busy-protocol violations.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int l, output int bad);
      l = 0;
      bad = 0;
      bus.start = 1'b1;
      bus.op = op;
      bus.src_a = a;
      bus.src_b = b;
      do begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         l++;
         if (bus.done == bus.busy) bad++;
      end while (!bus.done && l < 100);
   endtask

   // Reference: plain wide arithmetic; returns {div_zero, hi, lo}.
   function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      longint unsigned ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = 64'(a);
      ub = 64'(b);
      if (op[1] && b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
      case (op)
         2'd0: return {1'b0, 64'(ua * ub)};
         2'd1: return {1'b0, 64'(sa * sb)};
         2'd2: return {1'b0, a % b, a / b};
         default: return {1'b0, 32'(sa % sb), 32'(sa / sb)};
      endcase
   endfunction

   function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op[1]) return (b == 32'd0) ? 2 : 35;
      return (a == 32'd0 || b == 32'd0) ? ZL : 35;
   endfunction

   function automatic logic [31:0] pick();
      int k;
      k = $urandom_range(0, 9);
      return k == 0 ? 32'h0 : k == 1 ? 32'h8000_0000 : k == 2 ? 32'hFFFF_FFFF :
             k < 5 ? 32'($urandom_range(0, 20)) : 32'($urandom);
   endfunction

   initial begin
      tv[0] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 35};
      tv[1] = '{2'd1, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 35};
      tv[2] = '{2'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 35};
      tv[3] = '{2'd2, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1, 2};
      tv[4] = '{2'd2, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 35};
      tv[5] = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0, 35};
      tv[6] = '{2'd1, 32'd0,         32'd12345,     32'h0,         32'h0,         1'b0, ZL};
      tv[7] = '{2'd0, 32'd5,         32'd6,         32'h0,         32'd30,        1'b0, 35};
      bus.start = 1'b0;
      bus.cancel = 1'b0;
      bus.op = 2'd0;
      bus.src_a = '0;
      bus.src_b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", 64'(bus.busy), 64'd0);
      chk("reset done", 64'(bus.done), 64'd0);
      chk("reset div_zero", 64'(bus.div_zero), 64'd0);
      chk("reset hi", 64'(bus.hi), 64'd0);
      chk("reset lo", 64'(bus.lo), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) begin
         run_op(tv[i].op, tv[i].a, tv[i].b, lat, bb);
         chk($sformatf("vec%0d latency", i), 64'(lat), 64'(tv[i].lat));
         chk($sformatf("vec%0d busy", i), 64'(bb), 64'd0);
         chk($sformatf("vec%0d hi", i), 64'(bus.hi), 64'(tv[i].hi));
         chk($sformatf("vec%0d lo", i), 64'(bus.lo), 64'(tv[i].lo));
         chk($sformatf("vec%0d div_zero", i), 64'(bus.div_zero), 64'(tv[i].dz));
      end

      // START held through BUSY with changing inputs; the DONE-cycle START begins the next op.
      bus.start = 1'b1;
      bus.op = 2'd3;
      bus.src_a = 32'h8000_0000;
      bus.src_b = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      bus.op = 2'd0;
      bus.src_a = 32'd5;
      bus.src_b = 32'd6;
      lat = 1;
      while (!bus.done && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("held start latency", 64'(lat), 64'd35);
      chk("held start hi", 64'(bus.hi), 64'h0);
      chk("held start lo", 64'(bus.lo), 64'h8000_0000);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk("back-to-back busy at 36", 64'(bus.busy), 64'd1);
      lat = 36;
      while (!bus.done && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("back-to-back done cycle", 64'(lat), 64'd70);
      chk("back-to-back lo", 64'(bus.lo), 64'd30);

      // Cancel mid-multiply leaves the previous result in place.
      run_op(2'd2, 32'd100, 32'd7, lat, bb);
      chk("pre-cancel lo", 64'(bus.lo), 64'd14);
      bus.start = 1'b1;
      bus.op = 2'd0;
      bus.src_a = 32'd5;
      bus.src_b = 32'd6;
      for (int c = 1; c <= 11; c++) begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         bus.cancel = (c == 10);
      end
      chk("cancel busy", 64'(bus.busy), 64'd0);
      chk("cancel done", 64'(bus.done), 64'd0);
      cnt = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done) cnt++;
      end
      chk("cancel no done", 64'(cnt), 64'd0);
      chk("cancel hi kept", 64'(bus.hi), 64'd2);
      chk("cancel lo kept", 64'(bus.lo), 64'd14);

      // Asynchronous reset in the middle of a divide.
      bus.start = 1'b1;
      bus.op = 2'd2;
      bus.src_a = 32'd1000;
      bus.src_b = 32'd3;
      repeat (20) begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
      end
      chk("mid-divide busy", 64'(bus.busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("async reset busy", 64'(bus.busy), 64'd0);
      chk("async reset hi", 64'(bus.hi), 64'd0);
      chk("async reset lo", 64'(bus.lo), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post reset idle", 64'(bus.busy), 64'd0);

      for (int n = 0; n < 200; n++) begin
         rop = 2'($urandom_range(0, 3));
         ra = pick();
         rb = pick();
         ex = model(rop, ra, rb);
         run_op(rop, ra, rb, lat, bb);
         chk($sformatf("rnd%0d op%0d %h,%h hi", n, rop, ra, rb), 64'(bus.hi), 64'(ex[63:32]));
         chk($sformatf("rnd%0d op%0d %h,%h lo", n, rop, ra, rb), 64'(bus.lo), 64'(ex[31:0]));
         chk($sformatf("rnd%0d div_zero", n), 64'(bus.div_zero), 64'(ex[64]));
         chk($sformatf("rnd%0d latency", n), 64'(lat), 64'(exp_lat(rop, ra, rb)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
